// File: rtl/user_analog_wb_sar_ctrl_pkg.sv
// Shared register map, CTRL bit positions and SAR sequencer state encoding
// for the user-analog Wishbone SAR controller.
package user_analog_pkg;

  // word index taken from adr[4:2]
  localparam logic [2:0] ADR_CTRL   = 3'd0;
  localparam logic [2:0] ADR_OUT    = 3'd1;
  localparam logic [2:0] ADR_OEB    = 3'd2;
  localparam logic [2:0] ADR_IN     = 3'd3;
  localparam logic [2:0] ADR_RESULT = 3'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_SAR_EN = 3;
  localparam int CTRL_IE     = 4;
  localparam int CTRL_SETTLE = 8;

  typedef enum logic [1:0] {
    SAR_IDLE    = 2'd0,
    SAR_SETTLE  = 2'd1,
    SAR_COMPARE = 2'd2,
    SAR_DONE    = 2'd3
  } sar_state_t;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/user_analog_wb_sar_ctrl_if.sv
// Wishbone slave bus bundle for the user-analog SAR controller.
interface user_analog_wb_sar_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_analog_wb_sar_ctrl_sar_seq.sv
// SAR conversion sequencer: settle counter, trial bit walk MSB->LSB and code
// register; dac_code is held after DONE until the next start.
module user_analog_sar_seq
  import user_analog_pkg::*;
#(
  parameter int SAR_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          settle,
  input  logic                cmp,
  output logic                busy,
  output logic                done_pulse,
  output logic [SAR_BITS-1:0] code
);

  sar_state_t          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d, settle_eff;
  logic [SAR_BITS-1:0] code_q, code_d, trial_q, trial_d;

  assign settle_eff = (settle == 8'd0) ? 8'd1 : settle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SAR_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      trial_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      trial_q <= trial_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    trial_d = trial_q;
    case (state_q)
      SAR_IDLE: begin
        if (start) begin
          trial_d = '0;
          trial_d[SAR_BITS-1] = 1'b1;
          code_d  = trial_d;
          cnt_d   = settle_eff;
          state_d = SAR_SETTLE;
        end
      end
      SAR_SETTLE: begin
        if (cnt_q <= 8'd1) state_d = SAR_COMPARE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      SAR_COMPARE: begin
        // comparator low means Vin < Vdac: the trial bit was too large
        if (!cmp) code_d = code_q & ~trial_q;
        if (trial_q[0]) begin
          state_d = SAR_DONE;
        end else begin
          trial_d = trial_q >> 1;
          code_d  = code_d | trial_d;
          cnt_d   = settle_eff;
          state_d = SAR_SETTLE;
        end
      end
      SAR_DONE: state_d = SAR_IDLE;
      default:  state_d = SAR_IDLE;
    endcase
  end

  assign busy       = (state_q != SAR_IDLE);
  assign done_pulse = (state_q == SAR_DONE);
  assign code       = code_q;

endmodule

// File: rtl/user_analog_wb_sar_ctrl.sv
// Wishbone slave owning the analog wrapper GPIO bus, with a SAR sequencer that
// drives a DAC code on io_out and samples an off-core comparator on io_in.
module user_analog_wb_sar_ctrl
  import user_analog_pkg::*;
#(
  parameter int          NGPIO    = 27,
  parameter int          SAR_BITS = 8,
  parameter int          DAC_LSB  = 0,
  parameter int          CMP_IDX  = 13,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rstn_i,
  user_analog_wb_sar_ctrl_if.slave  wb,
  input  logic [NGPIO-1:0]          io_in,
  output logic [NGPIO-1:0]          io_out,
  output logic [NGPIO-1:0]          io_oeb,
  output logic                      irq_o
);

  logic                win, hit, wr, wr_ctrl, ctrl_b0, ctrl_b1;
  logic [2:0]          reg_sel;
  logic [31:0]         wmask, rdata;
  logic                sar_en_new, start;
  logic [7:0]          settle_new;

  logic                done_q, sar_en_q, ie_q;
  logic [7:0]          settle_q;
  logic [NGPIO-1:0]    out_q, oeb_q, sync0_q, sync1_q, io_out_c;
  logic [SAR_BITS-1:0] result_q, code;
  logic                busy, done_pulse;

  assign win     = (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign hit     = wb.wbs_cyc_i & wb.wbs_stb_i & win & ~wb.wbs_ack_o;
  assign wr      = hit & wb.wbs_we_i;
  assign reg_sel = wb.wbs_adr_i[4:2];
  assign wmask   = sel_mask(wb.wbs_sel_i);
  assign wr_ctrl = wr && (reg_sel == ADR_CTRL);
  assign ctrl_b0 = wr_ctrl & wb.wbs_sel_i[0];
  assign ctrl_b1 = wr_ctrl & wb.wbs_sel_i[1];

  // a single write may both configure and start, so the sequencer sees the new values
  assign sar_en_new = ctrl_b0 ? wb.wbs_dat_i[CTRL_SAR_EN] : sar_en_q;
  assign settle_new = ctrl_b1 ? wb.wbs_dat_i[CTRL_SETTLE+:8] : settle_q;
  assign start      = ctrl_b0 & wb.wbs_dat_i[CTRL_START] & sar_en_new;

  user_analog_sar_seq #(.SAR_BITS(SAR_BITS)) u_seq (
    .clk        (wb_clk_i),
    .rst_n      (wb_rstn_i),
    .start      (start),
    .settle     (settle_new),
    .cmp        (sync1_q[CMP_IDX]),
    .busy       (busy),
    .done_pulse (done_pulse),
    .code       (code)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= io_in;
      sync1_q <= sync0_q;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      done_q   <= 1'b0;
      sar_en_q <= 1'b0;
      ie_q     <= 1'b0;
      settle_q <= '0;
      out_q    <= '0;
      oeb_q    <= '1;
      result_q <= '0;
    end else begin
      sar_en_q <= sar_en_new;
      settle_q <= settle_new;
      if (ctrl_b0) ie_q <= wb.wbs_dat_i[CTRL_IE];
      // a DONE set on the same edge as a W1C takes precedence
      if (done_pulse)                              done_q <= 1'b1;
      else if (ctrl_b0 && wb.wbs_dat_i[CTRL_DONE]) done_q <= 1'b0;
      if (done_pulse) result_q <= code;
      if (wr && reg_sel == ADR_OUT)
        out_q <= (out_q & ~wmask[NGPIO-1:0]) | (wb.wbs_dat_i[NGPIO-1:0] & wmask[NGPIO-1:0]);
      if (wr && reg_sel == ADR_OEB)
        oeb_q <= (oeb_q & ~wmask[NGPIO-1:0]) | (wb.wbs_dat_i[NGPIO-1:0] & wmask[NGPIO-1:0]);
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      ADR_CTRL: begin
        rdata[CTRL_BUSY]       = busy;
        rdata[CTRL_DONE]       = done_q;
        rdata[CTRL_SAR_EN]     = sar_en_q;
        rdata[CTRL_IE]         = ie_q;
        rdata[CTRL_SETTLE+:8]  = settle_q;
      end
      ADR_OUT:    rdata[NGPIO-1:0]    = out_q;
      ADR_OEB:    rdata[NGPIO-1:0]    = oeb_q;
      ADR_IN:     rdata[NGPIO-1:0]    = sync1_q;
      ADR_RESULT: rdata[SAR_BITS-1:0] = result_q;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= hit;
      wb.wbs_dat_o <= hit ? rdata : '0;
    end
  end

  always_comb begin
    io_out_c = out_q;
    if (sar_en_q) io_out_c[DAC_LSB+:SAR_BITS] = code;
  end

  assign io_out = io_out_c;
  assign io_oeb = oeb_q;
  assign irq_o  = done_q & ie_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, wb.wbs_adr_i[7:5], wb.wbs_adr_i[1:0], wmask, wb.wbs_dat_i};

endmodule

// File: tb/tb_user_analog_wb_sar_ctrl.sv
// Randomized self-checking bench for user_analog_wb_sar_ctrl against a
// behavioural SAR model (threshold comparator => result equals threshold).
module tb_user_analog_wb_sar_ctrl;

  localparam logic [31:0] B      = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = B + 32'h00;
  localparam logic [31:0] A_OUT  = B + 32'h04;
  localparam logic [31:0] A_OEB  = B + 32'h08;
  localparam logic [31:0] A_IN   = B + 32'h0C;
  localparam logic [31:0] A_RES  = B + 32'h10;
  localparam logic [31:0] A_R18  = B + 32'h18;

  logic        wb_clk_i = 1'b0;
  logic        wb_rstn_i = 1'b0;
  logic [26:0] io_in, io_out, io_oeb;
  logic        irq_o;

  user_analog_wb_sar_ctrl_if wb();

  user_analog_wb_sar_ctrl dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rstn_i (wb_rstn_i),
    .wb        (wb.slave),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq_o     (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int errs = 0, checks = 0, cyc_cnt = 0;
  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  // comparator model: 0 threshold, 1 always high, 2 always low, 3 pass gpio_drv
  logic [26:0] gpio_drv = '0;
  int          cmp_mode = 3;
  logic [7:0]  thr = '0;

  always_comb begin
    io_in = gpio_drv;
    case (cmp_mode)
      0: io_in[13] = (io_out[7:0] <= thr);
      1: io_in[13] = 1'b1;
      2: io_in[13] = 1'b0;
      default: io_in[13] = gpio_drv[13];
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output logic ok);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge wb_clk_i); #1;
      if (wb.wbs_ack_o) begin ok = 1'b1; rd = wb.wbs_dat_o; break; end
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d; logic ok;
    wb_xfer(1'b1, adr, dat, sel, d, ok);
    chk("wr_ack", 32'(ok), 32'd1);
  endtask

  task automatic rd32(input logic [31:0] adr, output logic [31:0] d);
    logic ok;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, d, ok);
    chk("rd_ack", 32'(ok), 32'd1);
  endtask

  function automatic int exp_lat(input logic [7:0] s);
    int se = (s == 8'd0) ? 1 : int'(s);
    return 8 * (se + 1) + 1;
  endfunction

  function automatic logic [7:0] exp_res(input int mode, input logic [7:0] t);
    // largest code the comparator accepts
    return (mode == 0) ? t : (mode == 1) ? 8'hFF : 8'h00;
  endfunction

  // start (clearing DONE, SAR_EN=1, IE=1), measure cycles to irq, read RESULT
  task automatic run_conv(input logic [7:0] s, input int mode, input logic [7:0] t,
                          output int lat, output logic [31:0] res);
    int t0;
    cmp_mode = mode; thr = t;
    wr32(A_CTRL, {16'h0, s, 8'h1D}, 4'hF);
    t0 = cyc_cnt; lat = -1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge wb_clk_i); #1;
      if (irq_o) begin lat = cyc_cnt - t0; break; end
    end
    rd32(A_RES, res);
  endtask

  logic [31:0] d, out_m;
  logic        ok;
  int          lat, acks, t0;
  logic [7:0]  s, t;

  initial begin
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_adr_i = 0; wb.wbs_dat_i = 0; wb.wbs_sel_i = 0;

    // reset state
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_oeb", 32'(io_oeb), 32'h7FF_FFFF);
    chk("rst_out", 32'(io_out), 32'h0);
    chk("rst_ack", 32'(wb.wbs_ack_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    wb_rstn_i = 1'b1;
    rd32(A_CTRL, d);
    chk("ctrl_rst", d, 32'h0);
    @(posedge wb_clk_i); #1;
    chk("ack_1cyc", 32'(wb.wbs_ack_o), 32'h0);
    chk("dat_idle", wb.wbs_dat_o, 32'h0);

    // held strobe: one ack per two cycles
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 0; wb.wbs_adr_i = A_OEB;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      if (wb.wbs_ack_o) acks++;
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
    chk("held_acks", 32'(acks), 32'd2);

    // GPIO
    out_m = 32'h05A5_A5A5;
    wr32(A_OUT, out_m, 4'hF);
    chk("io_out", 32'(io_out), out_m);
    wr32(A_OEB, 32'h0, 4'hF);
    chk("io_oeb", 32'(io_oeb), 32'h0);
    gpio_drv = 27'h123_4567;
    repeat (3) @(posedge wb_clk_i);
    #1;
    rd32(A_IN, d);
    chk("in_sync", d, 32'h0123_4567);

    // byte lane write
    wr32(A_OUT, 32'hFFFF_FFFF, 4'b0010);
    out_m = (out_m & ~32'h0000_FF00) | 32'h0000_FF00;
    chk("lane_io", 32'(io_out), out_m);
    rd32(A_OUT, d);
    chk("lane_rd", d, out_m);

    // unmapped offsets and window miss
    wr32(A_R18, 32'hDEAD_BEEF, 4'hF);
    rd32(A_R18, d);
    chk("r18", d, 32'h0);
    wb_xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, d, ok);
    chk("miss_ack", 32'(ok), 32'h0);

    // main conversion
    run_conv(8'd4, 0, 8'hA5, lat, d);
    chk("lat_a5", 32'(lat), 32'(exp_lat(8'd4)));
    chk("res_a5", d, 32'(exp_res(0, 8'hA5)));
    chk("irq_a5", 32'(irq_o), 32'h1);
    chk("dac_hold", 32'(io_out[7:0]), 32'h0A5);

    // bounds
    run_conv(8'd0, 1, 8'h00, lat, d);
    chk("lat_s0", 32'(lat), 32'(exp_lat(8'd0)));
    chk("res_ff", d, 32'(exp_res(1, 8'h00)));
    run_conv(8'd3, 2, 8'h00, lat, d);
    chk("lat_s3", 32'(lat), 32'(exp_lat(8'd3)));
    chk("res_00", d, 32'(exp_res(2, 8'h00)));

    // randomized conversions
    for (int k = 0; k < 6; k++) begin
      s = 8'($urandom_range(2, 8));
      t = 8'($urandom_range(0, 255));
      run_conv(s, 0, t, lat, d);
      chk("lat_rnd", 32'(lat), 32'(exp_lat(s)));
      chk("res_rnd", d, 32'(exp_res(0, t)));
    end

    // START while busy is ignored; W1C of DONE on its set edge loses
    cmp_mode = 0; thr = 8'h3C;
    wr32(A_CTRL, {16'h0, 8'd4, 8'h1D}, 4'hF);
    t0 = cyc_cnt;
    repeat (10) @(posedge wb_clk_i);
    #1;
    wr32(A_CTRL, {16'h0, 8'd4, 8'h19}, 4'hF);
    for (int i = 0; i < 200 && cyc_cnt < t0 + exp_lat(8'd4) - 1; i++) begin
      @(posedge wb_clk_i); #1;
    end
    chk("pre_done", 32'(irq_o), 32'h0);
    wb_xfer(1'b1, A_CTRL, {16'h0, 8'd4, 8'h1C}, 4'hF, d, ok);
    chk("w1c_lat", 32'(cyc_cnt - t0), 32'(exp_lat(8'd4)));
    chk("w1c_irq", 32'(irq_o), 32'h1);
    rd32(A_CTRL, d);
    chk("w1c_ctrl", d, 32'h0000_041C);
    rd32(A_RES, d);
    chk("busy_res", d, 32'h3C);

    // reset mid-conversion
    cmp_mode = 1;
    wr32(A_CTRL, {16'h0, 8'd4, 8'h1D}, 4'hF);
    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_rstn_i = 1'b0;
    #1;
    chk("abort_oeb", 32'(io_oeb), 32'h7FF_FFFF);
    chk("abort_out", 32'(io_out), 32'h0);
    chk("abort_irq", 32'(irq_o), 32'h0);
    chk("abort_ack", 32'(wb.wbs_ack_o), 32'h0);
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rstn_i = 1'b1;
    rd32(A_RES, d);
    chk("abort_res", d, 32'h0);
    run_conv(8'd5, 0, 8'h5B, lat, d);
    chk("post_lat", 32'(lat), 32'(exp_lat(8'd5)));
    chk("post_res", d, 32'(exp_res(0, 8'h5B)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
